// File: rtl/id_ex_multi_issue_pkg.sv
// Shared definitions for the ID->EX multi-issue pipeline register.
package id_ex_multi_issue_pkg;

    localparam int LANES_DEF     = 2;
    localparam int PAYLOAD_W_DEF = 128;
    localparam int ADDR_W_DEF    = 5;
    localparam int PC_W_DEF      = 32;

    // Payload value loaded into EX when a lane is squashed by a flush.
    localparam logic [PAYLOAD_W_DEF-1:0] NOP_PAYLOAD = '0;

    // Low bit index of lane 'lane' in a flat vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/id_ex_multi_issue_if.sv
// ID-side bundle and EX-side registered lanes of the ID->EX boundary.
interface id_ex_multi_issue_if
    import id_ex_multi_issue_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int PC_W      = PC_W_DEF
);

    logic [LANES-1:0]           id_valid;
    logic [LANES*PAYLOAD_W-1:0] id_payload;
    logic [LANES*PC_W-1:0]      id_pc;
    logic [LANES*ADDR_W-1:0]    id_rs1;
    logic [LANES*ADDR_W-1:0]    id_rs2;
    logic [LANES-1:0]           id_rs1_en;
    logic [LANES-1:0]           id_rs2_en;
    logic [LANES*ADDR_W-1:0]    id_rd;
    logic [LANES-1:0]           id_wreg;
    logic                       id_ready;

    logic [LANES-1:0]           ex_valid;
    logic [LANES*PAYLOAD_W-1:0] ex_payload;
    logic [LANES*PC_W-1:0]      ex_pc;
    logic [LANES*ADDR_W-1:0]    ex_rd;
    logic [LANES-1:0]           ex_wreg;

    // Decode stage side: presents the bundle, watches the handshake and EX lanes.
    modport master (
        output id_valid, id_payload, id_pc, id_rs1, id_rs2,
               id_rs1_en, id_rs2_en, id_rd, id_wreg,
        input  id_ready,
        input  ex_valid, ex_payload, ex_pc, ex_rd, ex_wreg
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_payload, id_pc, id_rs1, id_rs2,
               id_rs1_en, id_rs2_en, id_rd, id_wreg,
        output id_ready,
        output ex_valid, ex_payload, ex_pc, ex_rd, ex_wreg
    );

endinterface

// File: rtl/id_ex_multi_issue_issue_split_logic.sv
// Combinational candidate / intra-bundle RAW / issue-set computation.
module issue_split_logic
    import id_ex_multi_issue_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [LANES-1:0]        id_valid,
    input  logic [LANES-1:0]        done,
    input  logic [LANES*ADDR_W-1:0] rs1,
    input  logic [LANES*ADDR_W-1:0] rs2,
    input  logic [LANES-1:0]        rs1_en,
    input  logic [LANES-1:0]        rs2_en,
    input  logic [LANES*ADDR_W-1:0] rd,
    input  logic [LANES-1:0]        wreg,
    output logic [LANES-1:0]        cand,
    output logic [LANES-1:0]        issue,
    output logic                    all_issued
);

    logic [ADDR_W-1:0] rs1_l [LANES];
    logic [ADDR_W-1:0] rs2_l [LANES];
    logic [ADDR_W-1:0] rd_l  [LANES];
    logic [LANES-1:0]  dep;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_slice
            assign rs1_l[gi] = rs1[lane_lo(gi, ADDR_W) +: ADDR_W];
            assign rs2_l[gi] = rs2[lane_lo(gi, ADDR_W) +: ADDR_W];
            assign rd_l[gi]  = rd[lane_lo(gi, ADDR_W) +: ADDR_W];
        end
    endgenerate

    assign cand = id_valid & ~done;

    // Lane k is dependent when an earlier pending lane writes a non-r0 register it reads.
    always_comb begin
        dep = '0;
        for (int k = 1; k < LANES; k++) begin
            for (int j = 0; j < k; j++) begin
                if (cand[k] && cand[j] && wreg[j] && (rd_l[j] != '0) &&
                    ((rs1_en[k] && (rs1_l[k] == rd_l[j])) ||
                     (rs2_en[k] && (rs2_l[k] == rd_l[j])))) begin
                    dep[k] = 1'b1;
                end
            end
        end
    end

    // Issue every pending lane below the first dependent one.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        issue   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (dep[k]) begin
                blocked = 1'b1;
            end
            issue[k] = cand[k] & ~blocked;
        end
    end

    assign all_issued = (issue == cand);

endmodule

// File: rtl/id_ex_multi_issue.sv
// ID->EX pipeline register that splits bundles on intra-bundle RAW hazards.
module id_ex_multi_issue
    import id_ex_multi_issue_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int PC_W      = PC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                excp_flush,
    input  logic                ertn_flush,
    input  logic                br_flush,
    input  logic                ex_stall,
    id_ex_multi_issue_if.slave  bus,
    output logic [31:0]         split_cnt
);

    logic [LANES-1:0]           ex_valid_reg,   ex_valid_next;
    logic [LANES-1:0]           ex_wreg_reg,    ex_wreg_next;
    logic [LANES*PAYLOAD_W-1:0] ex_payload_reg, ex_payload_next;
    logic [LANES*PC_W-1:0]      ex_pc_reg,      ex_pc_next;
    logic [LANES*ADDR_W-1:0]    ex_rd_reg,      ex_rd_next;
    logic [LANES-1:0]           done_reg,       done_next;
    logic [31:0]                split_cnt_reg;
    logic [31:0]                split_cnt_next;

    logic [LANES-1:0] cand;
    logic [LANES-1:0] issue;
    logic             all_issued;
    logic             any_flush;
    logic             ready;
    logic             split_event;

    issue_split_logic #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_split (
        .id_valid   (bus.id_valid),
        .done       (done_reg),
        .rs1        (bus.id_rs1),
        .rs2        (bus.id_rs2),
        .rs1_en     (bus.id_rs1_en),
        .rs2_en     (bus.id_rs2_en),
        .rd         (bus.id_rd),
        .wreg       (bus.id_wreg),
        .cand       (cand),
        .issue      (issue),
        .all_issued (all_issued)
    );

    // Exception/ertn and branch flush have identical effect here, so they merge.
    assign any_flush   = excp_flush | ertn_flush | br_flush;
    assign ready       = ~ex_stall & all_issued & ~any_flush;
    assign split_event = ~any_flush & ~ex_stall & ~ready;

    assign split_cnt_next = (split_event && (split_cnt_reg != 32'hFFFF_FFFF))
                            ? split_cnt_reg + 32'd1 : split_cnt_reg;

    // Next EX state and done mask: flush, then stall hold, then normal issue.
    always_comb begin
        ex_valid_next   = ex_valid_reg;
        ex_wreg_next    = ex_wreg_reg;
        ex_payload_next = ex_payload_reg;
        ex_pc_next      = ex_pc_reg;
        ex_rd_next      = ex_rd_reg;
        done_next       = done_reg;
        if (any_flush) begin
            ex_valid_next   = '0;
            ex_wreg_next    = '0;
            ex_payload_next = {LANES{PAYLOAD_W'(NOP_PAYLOAD)}};
            ex_pc_next      = '0;
            ex_rd_next      = '0;
            done_next       = '0;
        end else if (!ex_stall) begin
            ex_valid_next   = issue;
            ex_wreg_next    = bus.id_wreg & issue;
            ex_payload_next = bus.id_payload;
            ex_pc_next      = bus.id_pc;
            ex_rd_next      = bus.id_rd;
            done_next       = ready ? '0 : (done_reg | issue);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg   <= '0;
            ex_wreg_reg    <= '0;
            ex_payload_reg <= '0;
            ex_pc_reg      <= '0;
            ex_rd_reg      <= '0;
            done_reg       <= '0;
            split_cnt_reg  <= '0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            ex_wreg_reg    <= ex_wreg_next;
            ex_payload_reg <= ex_payload_next;
            ex_pc_reg      <= ex_pc_next;
            ex_rd_reg      <= ex_rd_next;
            done_reg       <= done_next;
            split_cnt_reg  <= split_cnt_next;
        end
    end

    assign bus.id_ready   = ready;
    assign bus.ex_valid   = ex_valid_reg;
    assign bus.ex_wreg    = ex_wreg_reg;
    assign bus.ex_payload = ex_payload_reg;
    assign bus.ex_pc      = ex_pc_reg;
    assign bus.ex_rd      = ex_rd_reg;
    assign split_cnt      = split_cnt_reg;

endmodule

// File: tb/tb_id_ex_multi_issue.sv
// Randomized and directed bench for id_ex_multi_issue with a lane-level reference model.
module tb_id_ex_multi_issue;

    localparam int L   = 4;
    localparam int PW  = 32;
    localparam int AW  = 5;
    localparam int PCW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        excp_flush, ertn_flush, br_flush, ex_stall;
    logic [31:0] split_cnt;

    id_ex_multi_issue_if #(.LANES(L), .PAYLOAD_W(PW), .ADDR_W(AW), .PC_W(PCW)) bus ();

    id_ex_multi_issue #(.LANES(L), .PAYLOAD_W(PW), .ADDR_W(AW), .PC_W(PCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .excp_flush (excp_flush),
        .ertn_flush (ertn_flush),
        .br_flush   (br_flush),
        .ex_stall   (ex_stall),
        .bus        (bus),
        .split_cnt  (split_cnt)
    );

    always #5 clk = ~clk;

    // Bundle presented by the bench's decode stage.
    logic          b_v    [L];
    logic [PW-1:0] b_pay  [L];
    logic [PCW-1:0] b_pc  [L];
    logic [AW-1:0] b_rs1  [L];
    logic [AW-1:0] b_rs2  [L];
    logic          b_rs1e [L];
    logic          b_rs2e [L];
    logic [AW-1:0] b_rd   [L];
    logic          b_wr   [L];

    // Reference model state.
    logic [L-1:0]     m_valid, m_wreg, m_done;
    logic [L*PW-1:0]  m_pay;
    logic [L*PCW-1:0] m_pc;
    logic [L*AW-1:0]  m_rd;
    logic [31:0]      m_cnt;

    int  total = 0;
    int  bad   = 0;
    int  ncyc  = 0;
    bit  last_rdy, last_fl, sat_load;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    task automatic clear_bundle();
        for (int k = 0; k < L; k++) begin
            b_v[k] = 0; b_pay[k] = '0; b_pc[k] = '0; b_rs1[k] = '0; b_rs2[k] = '0;
            b_rs1e[k] = 0; b_rs2e[k] = 0; b_rd[k] = '0; b_wr[k] = 0;
        end
    endtask

    task automatic set_lane(input int k, input int rd, input bit wr,
                            input int rs1, input bit rs1e, input int rs2, input bit rs2e);
        b_v[k] = 1; b_rd[k] = AW'(rd); b_wr[k] = wr;
        b_rs1[k] = AW'(rs1); b_rs1e[k] = rs1e; b_rs2[k] = AW'(rs2); b_rs2e[k] = rs2e;
        b_pay[k] = $urandom; b_pc[k] = $urandom;
    endtask

    task automatic random_bundle();
        for (int k = 0; k < L; k++) begin
            set_lane(k, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                     $urandom_range(0, 3), 1'($urandom));
            b_v[k] = 1'($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < L; k++) begin
            bus.id_valid[k]             = b_v[k];
            bus.id_payload[k*PW +: PW]  = b_pay[k];
            bus.id_pc[k*PCW +: PCW]     = b_pc[k];
            bus.id_rs1[k*AW +: AW]      = b_rs1[k];
            bus.id_rs2[k*AW +: AW]      = b_rs2[k];
            bus.id_rs1_en[k]            = b_rs1e[k];
            bus.id_rs2_en[k]            = b_rs2e[k];
            bus.id_rd[k*AW +: AW]       = b_rd[k];
            bus.id_wreg[k]              = b_wr[k];
        end
    endtask

    // Pending lanes issue in order until the first one that reads a register
    // written (non-r0) by an earlier pending lane of the same bundle.
    task automatic model_eval(output logic [L-1:0] iss, output bit rdy);
        int  first_dep;
        bit  pend [L];
        first_dep = L;
        for (int k = 0; k < L; k++) pend[k] = b_v[k] && !m_done[k];
        for (int k = 0; k < L && first_dep == L; k++) begin
            if (pend[k]) begin
                for (int j = 0; j < k; j++) begin
                    if (pend[j] && b_wr[j] && b_rd[j] != 0 &&
                        ((b_rs1e[k] && b_rs1[k] == b_rd[j]) || (b_rs2e[k] && b_rs2[k] == b_rd[j])))
                        first_dep = k;
                end
            end
        end
        for (int k = 0; k < L; k++) iss[k] = pend[k] && (k < first_dep);
        rdy = !ex_stall && !(excp_flush || ertn_flush || br_flush) && (first_dep == L);
    endtask

    task automatic step();
        logic [L-1:0] iss;
        bit rdy, fl;
        drive_bus();
        #1;
        model_eval(iss, rdy);
        fl = excp_flush || ertn_flush || br_flush;
        if (!rst) chk("id_ready", {127'b0, bus.id_ready}, {127'b0, rdy});
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = '0; m_wreg = '0; m_pay = '0; m_pc = '0; m_rd = '0; m_done = '0; m_cnt = '0;
        end else if (fl) begin
            m_valid = '0; m_wreg = '0; m_pay = '0; m_pc = '0; m_rd = '0; m_done = '0;
        end else if (!ex_stall) begin
            m_valid = iss;
            for (int k = 0; k < L; k++) begin
                m_pay[k*PW +: PW]   = b_pay[k];
                m_pc[k*PCW +: PCW]  = b_pc[k];
                m_rd[k*AW +: AW]    = b_rd[k];
                m_wreg[k]           = b_wr[k] && iss[k];
            end
            if (rdy) m_done = '0;
            else begin
                m_done = m_done | iss;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
        if (sat_load) m_cnt = 32'hFFFF_FFFF;
        chk("ex_valid",   128'(bus.ex_valid),   128'(m_valid));
        chk("ex_wreg",    128'(bus.ex_wreg),    128'(m_wreg));
        chk("ex_payload", 128'(bus.ex_payload), 128'(m_pay));
        chk("ex_pc",      128'(bus.ex_pc),      128'(m_pc));
        chk("ex_rd",      128'(bus.ex_rd),      128'(m_rd));
        chk("split_cnt",  128'(split_cnt),      128'(m_cnt));
        chk("done_mask",  128'(dut.done_reg),   128'(m_done));
        last_rdy = rdy;
        last_fl  = fl;
        ncyc++;
        $display("cyc=%0d rst=%0b fl=%0b stall=%0b id_valid=%b ready=%0b ex_valid=%b split_cnt=%0d",
                 ncyc, rst, fl, ex_stall, bus.id_valid, rdy, bus.ex_valid, split_cnt);
    endtask

    // Lane0 writes r4, lane1 reads r4 through rs1.
    task automatic raw_bundle();
        clear_bundle();
        set_lane(0, 4, 1, 1, 1, 2, 1);
        set_lane(1, 5, 1, 4, 1, 7, 1);
    endtask

    initial begin
        bit need_new;
        rst = 1; excp_flush = 0; ertn_flush = 0; br_flush = 0; ex_stall = 0; sat_load = 0;
        m_valid = '0; m_wreg = '0; m_pay = '0; m_pc = '0; m_rd = '0; m_done = '0; m_cnt = '0;
        clear_bundle();
        step();
        step();
        chk("reset_valid", 128'(bus.ex_valid), 128'(4'b0000));
        chk("reset_cnt",   128'(split_cnt),    128'(0));
        rst = 0;

        // Independent pair.
        clear_bundle();
        set_lane(0, 4, 1, 1, 1, 2, 1);
        set_lane(1, 5, 1, 6, 1, 7, 1);
        step();
        chk("pair_valid", 128'(bus.ex_valid), 128'(4'b0011));
        chk("pair_cnt",   128'(split_cnt),    128'(0));

        // RAW split over two cycles.
        raw_bundle();
        step();
        chk("raw1_valid", 128'(bus.ex_valid), 128'(4'b0001));
        chk("raw1_cnt",   128'(split_cnt),    128'(1));
        step();
        chk("raw2_valid", 128'(bus.ex_valid), 128'(4'b0010));
        chk("raw2_ready", 128'(last_rdy),     128'(1));

        // r0 never creates a hazard; a disabled source is not a hazard.
        clear_bundle();
        set_lane(0, 0, 1, 1, 1, 2, 1);
        set_lane(1, 5, 1, 0, 1, 7, 1);
        step();
        chk("r0_valid", 128'(bus.ex_valid), 128'(4'b0011));
        clear_bundle();
        set_lane(0, 4, 1, 1, 1, 2, 1);
        set_lane(1, 5, 1, 6, 1, 4, 0);
        step();
        chk("rs2dis_valid", 128'(bus.ex_valid), 128'(4'b0011));

        // Stall hold while a split is pending.
        raw_bundle();
        step();
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 128'(bus.ex_valid), 128'(4'b0001));
            chk("stall_cnt",   128'(split_cnt),    128'(2));
        end
        ex_stall = 0;
        step();
        chk("unstall_valid", 128'(bus.ex_valid), 128'(4'b0010));

        // Flush mid-split wins over stall, then a new bundle is accepted.
        raw_bundle();
        step();
        excp_flush = 1; ex_stall = 1;
        step();
        chk("flush_valid", 128'(bus.ex_valid), 128'(4'b0000));
        excp_flush = 0; ex_stall = 0;
        clear_bundle();
        set_lane(0, 4, 1, 1, 1, 2, 1);
        set_lane(1, 5, 1, 6, 1, 7, 1);
        step();
        chk("after_flush_valid", 128'(bus.ex_valid), 128'(4'b0011));

        // Reset in the middle of a split.
        raw_bundle();
        step();
        rst = 1;
        step();
        chk("rst_mid_valid", 128'(bus.ex_valid), 128'(4'b0000));
        chk("rst_mid_cnt",   128'(split_cnt),    128'(0));
        rst = 0;

        // Counter saturation.
        clear_bundle();
        force dut.split_cnt_next = 32'hFFFF_FFFF;
        sat_load = 1;
        step();
        release dut.split_cnt_next;
        sat_load = 0;
        raw_bundle();
        step();
        chk("sat_cnt", 128'(split_cnt), 128'(32'hFFFF_FFFF));
        step();

        // Randomized traffic with holds, stalls, flushes and the odd reset.
        need_new = 1;
        for (int n = 0; n < 1500; n++) begin
            if (need_new) random_bundle();
            excp_flush = ($urandom_range(0, 39) == 0);
            ertn_flush = ($urandom_range(0, 59) == 0);
            br_flush   = ($urandom_range(0, 29) == 0);
            ex_stall   = ($urandom_range(0, 4) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            step();
            need_new = last_rdy || last_fl || rst;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
